kamacore_stage_id: RTL and testbench

Instruction decode stage of the kamacore pipeline. It consumes the IF/ID pipeline register written by instruction fetch, decodes an RV32I-subset instruction, and reads two operands from the integer register file it owns. It detects load-use hazards, stalling fetch and inserting a bubble when needed, and registers the decoded bundle into the ID/EX stage. Writeback writes the register file through a dedicated port.

---
 rtl/kamacore_stage_id.sv | 201 ++++++++++++++++++++
 tb/tb_kamacore_stage_id.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/kamacore_stage_id.sv
// kamacore_stage_id: RV32I-subset decode, owns the integer register file.
// Latency: 1 cycle from the IF/ID register to the ID/EX register (id_*).
// Backpressure: combinational stall on load-use; a bubble is inserted and IF holds.
module kamacore_stage_id #(
  parameter int CPU_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [CPU_WIDTH-1:0]  if_instruction,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  input  logic                  flush,
  input  logic                  wb_we,
  input  logic [4:0]            wb_rd,
  input  logic [CPU_WIDTH-1:0]  wb_data,
  output logic                  stall,
  output logic                  id_valid,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [CPU_WIDTH-1:0]  id_rs1_data,
  output logic [CPU_WIDTH-1:0]  id_rs2_data,
  output logic [CPU_WIDTH-1:0]  id_imm,
  output logic [4:0]            id_rd,
  output logic [6:0]            id_opcode,
  output logic [2:0]            id_funct3,
  output logic                  id_funct7b5,
  output logic                  id_reg_write,
  output logic                  id_mem_read,
  output logic                  id_mem_write,
  output logic                  id_branch,
  output logic                  id_jump,
  output logic                  id_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [CPU_WIDTH-1:0] rf_q [32];

  logic [CPU_WIDTH-1:0] ins;
  logic [6:0]           opcode;
  logic [4:0]           rd, rs1, rs2;
  logic [31:0]          imm32;
  logic [CPU_WIDTH-1:0] imm;
  logic                 rs2_used, writes_rd, mem_read, mem_write, branch, jump, illegal;
  logic [CPU_WIDTH-1:0] rs1_data, rs2_data;

  // ID/EX pipeline register
  logic                  valid_q, reg_write_q, mem_read_q, mem_write_q, branch_q, jump_q, illegal_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [CPU_WIDTH-1:0]  rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]            rd_q;
  logic [6:0]            opcode_q;
  logic [2:0]            funct3_q;
  logic                  funct7b5_q;

  assign ins    = if_instruction;
  assign opcode = ins[6:0];
  assign rd     = ins[11:7];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];

  // Opcode decode: immediate format and control flags
  always_comb begin
    imm32     = 32'd0;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    illegal   = 1'b0;
    unique case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm32     = {ins[31:12], 12'd0};
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        imm32     = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        writes_rd = 1'b1;
        jump      = 1'b1;
      end
      OP_JALR: begin
        imm32     = {{20{ins[31]}}, ins[31:20]};
        writes_rd = 1'b1;
        jump      = 1'b1;
      end
      OP_BRANCH: begin
        imm32    = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        rs2_used = 1'b1;
        branch   = 1'b1;
      end
      OP_LOAD: begin
        imm32     = {{20{ins[31]}}, ins[31:20]};
        writes_rd = 1'b1;
        mem_read  = 1'b1;
      end
      OP_STORE: begin
        imm32     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        rs2_used  = 1'b1;
        mem_write = 1'b1;
      end
      OP_IMM: begin
        imm32     = {{20{ins[31]}}, ins[31:20]};
        writes_rd = 1'b1;
      end
      OP_OP: begin
        rs2_used  = 1'b1;
        writes_rd = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Widen the 32-bit immediate by repeating its sign bit
  assign imm = {{(CPU_WIDTH-31){imm32[31]}}, imm32[30:0]};

  // Register read with x0 hardwired and same-cycle writeback bypass
  always_comb begin
    rs1_data = rf_q[rs1];
    rs2_data = rf_q[rs2];
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1)) rs1_data = wb_data;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2)) rs2_data = wb_data;
    if (rs1 == 5'd0) rs1_data = '0;
    if (rs2 == 5'd0) rs2_data = '0;
  end

  // Load-use hazard against the load currently in ID/EX; a flush overrides it
  assign stall = if_valid & valid_q & mem_read_q & (rd_q != 5'd0) &
                 ((rd_q == rs1) | (rs2_used & (rd_q == rs2))) & ~flush;

  // Register file write port (x0 never written)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // ID/EX update: reset, then flush/stall bubble, then load decoded bundle
  always_ff @(posedge clk) begin
    if (rst || flush || stall) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7b5_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= if_valid;
      pc_q        <= if_pc;
      rs1_data_q  <= rs1_data;
      rs2_data_q  <= rs2_data;
      imm_q       <= imm;
      rd_q        <= rd;
      opcode_q    <= opcode;
      funct3_q    <= ins[14:12];
      funct7b5_q  <= ins[30];
      reg_write_q <= if_valid & writes_rd & (rd != 5'd0);
      mem_read_q  <= if_valid & mem_read;
      mem_write_q <= if_valid & mem_write;
      branch_q    <= if_valid & branch;
      jump_q      <= if_valid & jump;
      illegal_q   <= if_valid & illegal;
    end
  end

  assign id_valid     = valid_q;
  assign id_pc        = pc_q;
  assign id_rs1_data  = rs1_data_q;
  assign id_rs2_data  = rs2_data_q;
  assign id_imm       = imm_q;
  assign id_rd        = rd_q;
  assign id_opcode    = opcode_q;
  assign id_funct3    = funct3_q;
  assign id_funct7b5  = funct7b5_q;
  assign id_reg_write = reg_write_q;
  assign id_mem_read  = mem_read_q;
  assign id_mem_write = mem_write_q;
  assign id_branch    = branch_q;
  assign id_jump      = jump_q;
  assign id_illegal   = illegal_q;

endmodule

// File: tb/tb_kamacore_stage_id.sv
// Directed bench for kamacore_stage_id: decode, operands, hazards, reset.
module tb_kamacore_stage_id;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] I_ADDI1  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_ADD2   = 32'h00110133; // add x2,x2,x1
  localparam logic [31:0] I_LW3    = 32'h0000A183; // lw x3,0(x1)
  localparam logic [31:0] I_ADD4   = 32'h00318233; // add x4,x3,x3
  localparam logic [31:0] I_ADDI6  = 32'h00300313; // addi x6,x0,3 (rs2 field = 3)
  localparam logic [31:0] I_BEQ    = 32'hFE000EE3;
  localparam logic [31:0] I_JAL    = 32'h0080006F;
  localparam logic [31:0] I_SW     = 32'hFE112E23; // sw x1,-4(x2)
  localparam logic [31:0] I_BAD    = 32'h0000007F;
  localparam logic [31:0] I_ADDI5  = 32'h00000293; // addi x5,x0,0

  kamacore_stage_id #(.CPU_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd), .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch), .id_jump(id_jump), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one clock edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    if_valid       = v;
    if_instruction = ins;
    if_pc          = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    drive(1'b0, 32'd0, 32'd0);
    tick(); tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_imm", id_imm, 32'd0);
    check("rst_rd", {27'd0, id_rd}, 32'd0);
    rst = 1'b0;

    // addi x1,x0,5
    drive(1'b1, I_ADDI1, 32'h100);
    tick();
    check("addi_valid", {31'd0, id_valid}, 32'd1);
    check("addi_rd", {27'd0, id_rd}, 32'd1);
    check("addi_imm", id_imm, 32'd5);
    check("addi_rs1", id_rs1_data, 32'd0);
    check("addi_regw", {31'd0, id_reg_write}, 32'd1);
    check("addi_pc", id_pc, 32'h100);
    check("addi_opc", {25'd0, id_opcode}, 32'h13);

    // x2 <= DEADBEEF while IF/ID is empty
    drive(1'b0, 32'd0, 32'd0);
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEADBEEF;
    tick();
    check("empty_valid", {31'd0, id_valid}, 32'd0);
    check("empty_regw", {31'd0, id_reg_write}, 32'd0);

    // add x2,x2,x1 with x1<=7 written on the same edge
    wb_rd = 5'd1; wb_data = 32'd7;
    drive(1'b1, I_ADD2, 32'h104);
    tick();
    wb_we = 1'b0;
    check("add_rs1", id_rs1_data, 32'hDEADBEEF);
    check("add_rs2_bypass", id_rs2_data, 32'd7);
    check("add_rd", {27'd0, id_rd}, 32'd2);

    // load-use: lw x3 then add x4,x3,x3
    drive(1'b1, I_LW3, 32'h108);
    tick();
    check("lw_memrd", {31'd0, id_mem_read}, 32'd1);
    check("lw_rs1", id_rs1_data, 32'd7);
    check("lw_f3", {29'd0, id_funct3}, 32'd2);
    drive(1'b1, I_ADD4, 32'h10C);
    #1;
    check("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    check("lu_bubble", {31'd0, id_valid}, 32'd0);
    check("lu_bubble_memrd", {31'd0, id_mem_read}, 32'd0);
    check("lu_stall_drop", {31'd0, stall}, 32'd0);
    tick();
    check("lu_add_valid", {31'd0, id_valid}, 32'd1);
    check("lu_add_rd", {27'd0, id_rd}, 32'd4);
    check("lu_add_pc", id_pc, 32'h10C);

    // same pair, flush during the would-be stall cycle
    drive(1'b1, I_LW3, 32'h200);
    tick();
    drive(1'b1, I_ADD4, 32'h204);
    flush = 1'b1;
    #1;
    check("fl_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    drive(1'b1, I_ADD4, 32'h300);
    #1;
    check("fl_bubble", {31'd0, id_valid}, 32'd0);
    check("fl_no_stall", {31'd0, stall}, 32'd0);
    tick();
    check("fl_next_valid", {31'd0, id_valid}, 32'd1);
    check("fl_next_pc", id_pc, 32'h300);

    // rs2 field matching the load rd does not stall an I-type
    drive(1'b1, I_LW3, 32'h400);
    tick();
    drive(1'b1, I_ADDI6, 32'h404);
    #1;
    check("rs2_unused_stall", {31'd0, stall}, 32'd0);
    tick();
    check("addi6_imm", id_imm, 32'd3);

    // immediates
    drive(1'b1, I_BEQ, 32'h500);
    tick();
    check("beq_imm", id_imm, 32'hFFFFFFFC);
    check("beq_branch", {31'd0, id_branch}, 32'd1);
    check("beq_regw", {31'd0, id_reg_write}, 32'd0);
    drive(1'b1, I_JAL, 32'h504);
    tick();
    check("jal_imm", id_imm, 32'd8);
    check("jal_jump", {31'd0, id_jump}, 32'd1);
    check("jal_rd0_regw", {31'd0, id_reg_write}, 32'd0);
    drive(1'b1, I_SW, 32'h508);
    tick();
    check("sw_imm", id_imm, 32'hFFFFFFFC);
    check("sw_memwr", {31'd0, id_mem_write}, 32'd1);
    check("sw_rs1", id_rs1_data, 32'hDEADBEEF);
    check("sw_rs2", id_rs2_data, 32'd7);
    check("sw_f7b5", {31'd0, id_funct7b5}, 32'd1);

    // illegal opcode
    drive(1'b1, I_BAD, 32'h50C);
    tick();
    check("bad_illegal", {31'd0, id_illegal}, 32'd1);
    check("bad_valid", {31'd0, id_valid}, 32'd1);
    check("bad_ctrl", {27'd0, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump}, 32'd0);

    // writes to x0 are dropped, including the same-cycle bypass
    drive(1'b0, 32'd0, 32'd0);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
    tick();
    drive(1'b1, I_ADDI5, 32'h510);
    tick();
    wb_we = 1'b0;
    check("x0_rs1", id_rs1_data, 32'd0);
    check("x0_rd", {27'd0, id_rd}, 32'd5);
    check("x0_illegal", {31'd0, id_illegal}, 32'd0);

    // reset asserted mid-stall
    drive(1'b1, I_LW3, 32'h600);
    tick();
    drive(1'b1, I_ADD4, 32'h604);
    #1;
    check("rs_pre_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    tick();
    check("rs_stall", {31'd0, stall}, 32'd0);
    check("rs_valid", {31'd0, id_valid}, 32'd0);
    check("rs_pc", id_pc, 32'd0);
    check("rs_ctrl", {26'd0, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal}, 32'd0);
    rst = 1'b0;
    // register file cleared: x2 and x1 read back 0
    drive(1'b1, I_ADD2, 32'h700);
    tick();
    check("rs_rf_x2", id_rs1_data, 32'd0);
    check("rs_rf_x1", id_rs2_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard time limit so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
